// File: rtl/len5_mem_arbiter.sv
// len5_mem_arbiter
//   Arbitrates the fetch, load and store ports onto a single in-order memory
//   port and routes each memory response back to the requester that issued it.
//   A small outstanding-request FIFO records {source, addr[2], drop} for every
//   granted request. Responses are matched against the FIFO head. A fetch
//   flush marks fetch entries as drop, so their responses are consumed silently.
//
//   Ports
//     clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//     flush_i              discard in-flight fetch responses
//     instr_*              fetch request/grant and response (32-bit rdata)
//     load_*               load request/grant and response (XLEN rdata, tag)
//     store_*              store request/grant and response (tag only)
//     mem_*                memory-side request/grant and in-order response
//
//   Configuration
//     LEN5_ARB_RR_EN       defined: round-robin arbitration.
//                          undefined: fixed priority STORE > LOAD > INSTR.

package len5_mem_arbiter_pkg;
   typedef logic [3:0] except_code_t;

   typedef enum logic [1:0] {
      SRC_INSTR = 2'd0,
      SRC_LOAD  = 2'd1,
      SRC_STORE = 2'd2
   } src_e;

   typedef struct packed {
      src_e src;
      logic a2;
      logic drop;
   } outst_t;
endpackage

module len5_mem_arbiter
   import len5_mem_arbiter_pkg::*;
#(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   // fetch
   input  logic               instr_req_i,
   input  logic [XLEN-1:0]    instr_addr_i,
   output logic               instr_gnt_o,
   output logic               instr_rvalid_o,
   input  logic               instr_rready_i,
   output logic [31:0]        instr_rdata_o,
   output logic               instr_except_raised_o,
   output except_code_t       instr_except_code_o,
   // load
   input  logic               load_req_i,
   input  logic [XLEN-1:0]    load_addr_i,
   input  logic [7:0]         load_be_i,
   input  logic [TAG_W-1:0]   load_tag_i,
   output logic               load_gnt_o,
   output logic               load_rvalid_o,
   input  logic               load_rready_i,
   output logic [XLEN-1:0]    load_rdata_o,
   output logic [TAG_W-1:0]   load_tag_o,
   output logic               load_except_raised_o,
   output except_code_t       load_except_code_o,
   // store
   input  logic               store_req_i,
   input  logic [XLEN-1:0]    store_addr_i,
   input  logic [7:0]         store_be_i,
   input  logic [XLEN-1:0]    store_wdata_i,
   input  logic [TAG_W-1:0]   store_tag_i,
   output logic               store_gnt_o,
   output logic               store_rvalid_o,
   input  logic               store_rready_i,
   output logic [TAG_W-1:0]   store_tag_o,
   output logic               store_except_raised_o,
   output except_code_t       store_except_code_o,
   // memory
   output logic               mem_req_o,
   input  logic               mem_gnt_i,
   output logic               mem_we_o,
   output logic [XLEN-1:0]    mem_addr_o,
   output logic [7:0]         mem_be_o,
   output logic [XLEN-1:0]    mem_wdata_o,
   output logic [TAG_W-1:0]   mem_tag_o,
   input  logic               mem_rvalid_i,
   output logic               mem_rready_o,
   input  logic [XLEN-1:0]    mem_rdata_i,
   input  logic [TAG_W-1:0]   mem_tag_i,
   input  logic               mem_except_raised_i,
   input  except_code_t       mem_except_code_i
);

   localparam int unsigned    PTR_W    = $clog2(MAX_OUTST);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUTST);

   outst_t           fifo_q [MAX_OUTST];
   outst_t           fifo_d [MAX_OUTST];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             lock_q, lock_d;
   src_e             lock_src_q, lock_src_d;
`ifdef LEN5_ARB_RR_EN
   src_e             rr_q, rr_d;
`endif

   logic [2:0] req;
   logic       lock_eff;
   logic       fifo_full, fifo_empty;
   src_e       sel;
   logic       sel_req;
   logic       grant;
   outst_t     head;
   logic       head_drop;
   logic       resp_ok;
   logic       pop;

   // ---------------------------------------------------------------- select
   always_comb begin
      // a flushed fetch request never competes and drops any fetch lock
      req       = {store_req_i, load_req_i, instr_req_i & ~flush_i};
      lock_eff  = lock_q & ~(flush_i & (lock_src_q == SRC_INSTR));
      fifo_full  = (cnt_q == FULL_CNT);
      fifo_empty = (cnt_q == '0);

      sel = SRC_INSTR;
      if (lock_eff) begin
         sel = lock_src_q;
      end else begin
`ifdef LEN5_ARB_RR_EN
         // rr_q names the requester searched first
         case (rr_q)
            SRC_LOAD:  sel = req[1] ? SRC_LOAD  : req[2] ? SRC_STORE : req[0] ? SRC_INSTR : SRC_LOAD;
            SRC_STORE: sel = req[2] ? SRC_STORE : req[0] ? SRC_INSTR : req[1] ? SRC_LOAD  : SRC_STORE;
            default:   sel = req[0] ? SRC_INSTR : req[1] ? SRC_LOAD  : req[2] ? SRC_STORE : SRC_INSTR;
         endcase
`else
         sel = req[2] ? SRC_STORE : req[1] ? SRC_LOAD : SRC_INSTR;
`endif
      end

      case (sel)
         SRC_STORE: sel_req = req[2];
         SRC_LOAD:  sel_req = req[1];
         default:   sel_req = req[0];
      endcase

      mem_req_o   = rst_ni & sel_req & ~fifo_full;
      grant       = mem_req_o & mem_gnt_i;
      instr_gnt_o = grant & (sel == SRC_INSTR);
      load_gnt_o  = grant & (sel == SRC_LOAD);
      store_gnt_o = grant & (sel == SRC_STORE);
   end

   // --------------------------------------------------------- request fields
   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = instr_addr_i;
      mem_be_o    = instr_addr_i[2] ? 8'hF0 : 8'h0F;
      mem_wdata_o = '0;
      mem_tag_o   = '0;
      case (sel)
         SRC_LOAD: begin
            mem_addr_o = load_addr_i;
            mem_be_o   = load_be_i;
            mem_tag_o  = load_tag_i;
         end
         SRC_STORE: begin
            mem_we_o    = 1'b1;
            mem_addr_o  = store_addr_i;
            mem_be_o    = store_be_i;
            mem_wdata_o = store_wdata_i;
            mem_tag_o   = store_tag_i;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------- response
   always_comb begin
      head      = fifo_q[rd_ptr_q];
      // a flush in the same cycle already discards a fetch response at the head
      head_drop = head.drop | (flush_i & (head.src == SRC_INSTR));
      resp_ok   = rst_ni & ~fifo_empty;

      mem_rready_o = 1'b1;
      if (resp_ok && !head_drop) begin
         case (head.src)
            SRC_LOAD:  mem_rready_o = load_rready_i;
            SRC_STORE: mem_rready_o = store_rready_i;
            default:   mem_rready_o = instr_rready_i;
         endcase
      end

      instr_rvalid_o = resp_ok & mem_rvalid_i & ~head_drop & (head.src == SRC_INSTR);
      load_rvalid_o  = resp_ok & mem_rvalid_i & ~head_drop & (head.src == SRC_LOAD);
      store_rvalid_o = resp_ok & mem_rvalid_i & ~head_drop & (head.src == SRC_STORE);
      pop            = resp_ok & mem_rvalid_i & mem_rready_o;

      instr_rdata_o         = head.a2 ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
      instr_except_raised_o = mem_except_raised_i;
      instr_except_code_o   = mem_except_code_i;
      load_rdata_o          = mem_rdata_i;
      load_tag_o            = mem_tag_i;
      load_except_raised_o  = mem_except_raised_i;
      load_except_code_o    = mem_except_code_i;
      store_tag_o           = mem_tag_i;
      store_except_raised_o = mem_except_raised_i;
      store_except_code_o   = mem_except_code_i;
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;

      if (flush_i) begin
         for (int unsigned i = 0; i < MAX_OUTST; i++) begin
            if (fifo_d[i].src == SRC_INSTR) fifo_d[i].drop = 1'b1;
         end
      end
      if (grant) begin
         fifo_d[wr_ptr_q] = '{src:  sel,
                              a2:   (sel == SRC_INSTR) & instr_addr_i[2],
                              drop: (sel == SRC_INSTR) & flush_i};
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({grant, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      // while full nothing is granted, so the current selection is kept as is
      lock_d     = fifo_full ? lock_eff : (mem_req_o & ~mem_gnt_i);
      lock_src_d = lock_d ? sel : lock_src_q;

`ifdef LEN5_ARB_RR_EN
      rr_d = rr_q;
      if (grant) begin
         case (sel)
            SRC_INSTR: rr_d = SRC_LOAD;
            SRC_LOAD:  rr_d = SRC_STORE;
            default:   rr_d = SRC_INSTR;
         endcase
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         lock_q     <= 1'b0;
         lock_src_q <= SRC_INSTR;
`ifdef LEN5_ARB_RR_EN
         rr_q       <= SRC_INSTR;
`endif
      end else begin
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         lock_q     <= lock_d;
         lock_src_q <= lock_src_d;
`ifdef LEN5_ARB_RR_EN
         rr_q       <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_len5_mem_arbiter.sv
module tb_len5_mem_arbiter;
   import len5_mem_arbiter_pkg::*;

   localparam int unsigned XLEN      = 64;
   localparam int unsigned TAG_W     = 4;
   localparam int unsigned MAX_OUTST = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n, flush;
   logic               instr_req_i, instr_gnt_o, instr_rvalid_o, instr_rready_i;
   logic [XLEN-1:0]    instr_addr_i;
   logic [31:0]        instr_rdata_o;
   logic               instr_except_raised_o;
   except_code_t       instr_except_code_o;
   logic               load_req_i, load_gnt_o, load_rvalid_o, load_rready_i;
   logic [XLEN-1:0]    load_addr_i, load_rdata_o;
   logic [7:0]         load_be_i;
   logic [TAG_W-1:0]   load_tag_i, load_tag_o;
   logic               load_except_raised_o;
   except_code_t       load_except_code_o;
   logic               store_req_i, store_gnt_o, store_rvalid_o, store_rready_i;
   logic [XLEN-1:0]    store_addr_i, store_wdata_i;
   logic [7:0]         store_be_i;
   logic [TAG_W-1:0]   store_tag_i, store_tag_o;
   logic               store_except_raised_o;
   except_code_t       store_except_code_o;
   logic               mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_rready_o;
   logic [XLEN-1:0]    mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [7:0]         mem_be_o;
   logic [TAG_W-1:0]   mem_tag_o, mem_tag_i;
   logic               mem_except_raised_i;
   except_code_t       mem_except_code_i;

   len5_mem_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .MAX_OUTST(MAX_OUTST)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rready_i(instr_rready_i),
      .instr_rdata_o(instr_rdata_o), .instr_except_raised_o(instr_except_raised_o),
      .instr_except_code_o(instr_except_code_o),
      .load_req_i(load_req_i), .load_addr_i(load_addr_i), .load_be_i(load_be_i),
      .load_tag_i(load_tag_i), .load_gnt_o(load_gnt_o), .load_rvalid_o(load_rvalid_o),
      .load_rready_i(load_rready_i), .load_rdata_o(load_rdata_o), .load_tag_o(load_tag_o),
      .load_except_raised_o(load_except_raised_o), .load_except_code_o(load_except_code_o),
      .store_req_i(store_req_i), .store_addr_i(store_addr_i), .store_be_i(store_be_i),
      .store_wdata_i(store_wdata_i), .store_tag_i(store_tag_i), .store_gnt_o(store_gnt_o),
      .store_rvalid_o(store_rvalid_o), .store_rready_i(store_rready_i),
      .store_tag_o(store_tag_o), .store_except_raised_o(store_except_raised_o),
      .store_except_code_o(store_except_code_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_tag_o(mem_tag_o), .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
      .mem_rdata_i(mem_rdata_i), .mem_tag_i(mem_tag_i),
      .mem_except_raised_i(mem_except_raised_i), .mem_except_code_i(mem_except_code_i)
   );

   typedef struct {
      int unsigned src;
      logic [63:0] addr;
      logic [7:0]  be;
      logic        we;
   } gnt_exp_t;

   typedef struct {
      int unsigned port;
      logic [63:0] data;
      logic [3:0]  tag;
      logic        exc;
   } rsp_exp_t;

   gnt_exp_t    gnt_q[$];
   rsp_exp_t    rsp_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   localparam logic [63:0] RD_PAT = 64'hDEADBEEF_01234567;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   // ------------------------------------------------------------ monitor
   gnt_exp_t    ge;
   rsp_exp_t    re;
   int unsigned got_src;

   task automatic rsp_event(input int unsigned port, input logic [63:0] data,
                            input logic [3:0] tag, input logic exc);
      if (rsp_q.size() == 0) begin
         check("unexpected_response", 64'(port), 64'hFF);
      end else begin
         re = rsp_q.pop_front();
         check("rsp_port", 64'(port), 64'(re.port));
         check("rsp_data", data, re.data);
         check("rsp_tag",  64'(tag), 64'(re.tag));
         check("rsp_exc",  64'(exc), 64'(re.exc));
      end
   endtask

   always @(negedge clk) begin
      if (mem_req_o && mem_gnt_i) begin
         got_src = store_gnt_o ? 2 : load_gnt_o ? 1 : instr_gnt_o ? 0 : 3;
         if (gnt_q.size() == 0) begin
            check("unexpected_grant", 64'(got_src), 64'hFF);
         end else begin
            ge = gnt_q.pop_front();
            check("gnt_src",    64'(got_src), 64'(ge.src));
            check("gnt_onehot", 64'($countones({instr_gnt_o, load_gnt_o, store_gnt_o})), 64'd1);
            check("gnt_addr",   mem_addr_o, ge.addr);
            check("gnt_be",     64'(mem_be_o), 64'(ge.be));
            check("gnt_we",     64'(mem_we_o), 64'(ge.we));
         end
      end
      if (instr_rvalid_o && instr_rready_i)
         rsp_event(0, {32'h0, instr_rdata_o}, 4'h0, instr_except_raised_o);
      if (load_rvalid_o && load_rready_i)
         rsp_event(1, load_rdata_o, load_tag_o, load_except_raised_o);
      if (store_rvalid_o && store_rready_i)
         rsp_event(2, 64'h0, store_tag_o, store_except_raised_o);
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0;
      instr_req_i = 1'b0; load_req_i = 1'b0; store_req_i = 1'b0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_tag_i = '0;
      mem_except_raised_i = 1'b0; mem_except_code_i = '0;
   endtask

   task automatic exp_gnt(input int unsigned src, input logic [63:0] addr,
                          input logic [7:0] be, input logic we);
      gnt_q.push_back('{src: src, addr: addr, be: be, we: we});
   endtask

   task automatic exp_rsp(input int unsigned port, input logic [63:0] data,
                          input logic [3:0] tag, input logic exc);
      rsp_q.push_back('{port: port, data: data, tag: tag, exc: exc});
   endtask

   task automatic drop_req(input int unsigned src);
      case (src)
         0:       instr_req_i = 1'b0;
         1:       load_req_i  = 1'b0;
         default: store_req_i = 1'b0;
      endcase
   endtask

   task automatic respond(input int unsigned src);
      mem_rvalid_i = 1'b1;
      case (src)
         0: begin
            mem_rdata_i = 64'h1111_2222_3333_4444; mem_tag_i = 4'h0;
            exp_rsp(0, 64'h3333_4444, 4'h0, 1'b0);
         end
         1: begin
            mem_rdata_i = 64'h5555_6666_7777_8888; mem_tag_i = 4'h1;
            exp_rsp(1, 64'h5555_6666_7777_8888, 4'h1, 1'b0);
         end
         default: begin
            mem_rdata_i = 64'h0; mem_tag_i = 4'h2;
            exp_rsp(2, 64'h0, 4'h2, 1'b0);
         end
      endcase
   endtask

   int unsigned order[3];
   logic [63:0] a_of[3];
   logic [63:0] d_of[4];

   initial begin
      idle();
      instr_rready_i = 1'b0; load_rready_i = 1'b0; store_rready_i = 1'b0;
      instr_addr_i = 64'h40; load_addr_i = '0; load_be_i = '0; load_tag_i = '0;
      store_addr_i = '0; store_be_i = '0; store_wdata_i = '0; store_tag_i = '0;
      rst_n = 1'b0;
      // requests and responses presented during reset must be fully masked
      instr_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
      #2;
      check("rst_mem_req",   64'(mem_req_o), 64'd0);
      check("rst_instr_gnt", 64'(instr_gnt_o), 64'd0);
      check("rst_rready",    64'(mem_rready_o), 64'd1);
      check("rst_rvalid",    64'({instr_rvalid_o, load_rvalid_o, store_rvalid_o}), 64'd0);
      tick(); tick();
      idle();
      instr_rready_i = 1'b1; load_rready_i = 1'b1; store_rready_i = 1'b1;
      rst_n = 1'b1;

      // fetch from upper word
      tick();
      instr_req_i = 1'b1; instr_addr_i = 64'h1004; mem_gnt_i = 1'b1;
      exp_gnt(0, 64'h1004, 8'hF0, 1'b0);
      #1;
      check("instr_wdata", mem_wdata_o, 64'h0);
      check("instr_tag",   64'(mem_tag_o), 64'h0);
      tick();
      instr_req_i = 1'b0; mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
      exp_rsp(0, 64'hAAAA_BBBB, 4'h0, 1'b0);
      tick();
      idle();

      // lock held on a stalled load while a store arrives
      tick();
      load_req_i = 1'b1; load_addr_i = 64'h100; load_be_i = 8'hFF; load_tag_i = 4'h3;
      #1;
      check("lock_c1_addr", mem_addr_o, 64'h100);
      check("lock_c1_req",  64'(mem_req_o), 64'd1);
      tick();
      store_req_i = 1'b1; store_addr_i = 64'h200; store_be_i = 8'h0F;
      store_wdata_i = 64'h1122_3344_5566_7788; store_tag_i = 4'h5;
      #1;
      check("lock_c2_addr", mem_addr_o, 64'h100);
      check("lock_c2_sgnt", 64'(store_gnt_o), 64'd0);
      tick();
      #1;
      check("lock_c3_addr", mem_addr_o, 64'h100);
      tick();
      mem_gnt_i = 1'b1;
      exp_gnt(1, 64'h100, 8'hFF, 1'b0);
      #1;
      check("lock_load_gnt", 64'(load_gnt_o), 64'd1);
      tick();
      load_req_i = 1'b0;
      exp_gnt(2, 64'h200, 8'h0F, 1'b1);
      #1;
      check("store_wdata", mem_wdata_o, 64'h1122_3344_5566_7788);
      check("store_tag",   64'(mem_tag_o), 64'h5);
      tick();
      store_req_i = 1'b0; mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 64'hCAFE_F00D_1234_5678; mem_tag_i = 4'h3;
      mem_except_raised_i = 1'b1;
      exp_rsp(1, 64'hCAFE_F00D_1234_5678, 4'h3, 1'b1);
      tick();
      mem_rdata_i = 64'h0; mem_tag_i = 4'h5; mem_except_raised_i = 1'b0;
      exp_rsp(2, 64'h0, 4'h5, 1'b0);
      tick();
      idle();

      // all three requesting at once, each drops after its grant
`ifdef LEN5_ARB_RR_EN
      order = '{0, 1, 2};
`else
      order = '{2, 1, 0};
`endif
      a_of = '{64'h2000, 64'h3008, 64'h4010};
      tick();
      instr_req_i = 1'b1; instr_addr_i = a_of[0];
      load_req_i  = 1'b1; load_addr_i  = a_of[1]; load_be_i  = 8'hFF; load_tag_i  = 4'h1;
      store_req_i = 1'b1; store_addr_i = a_of[2]; store_be_i = 8'hFF; store_tag_i = 4'h2;
      mem_gnt_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_gnt(order[i], a_of[order[i]], (order[i] == 0) ? 8'h0F : 8'hFF, order[i] == 2);
         tick();
         drop_req(order[i]);
      end
      mem_gnt_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         respond(order[i]);
         tick();
      end
      idle();

      // fill the outstanding FIFO, fifth request must wait for a pop
      d_of = '{64'h0123_4567, 64'hDEAD_BEEF, 64'h0123_4567, 64'hDEAD_BEEF};
      tick();
      instr_req_i = 1'b1; mem_gnt_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         instr_addr_i = 64'(4 * i);
         exp_gnt(0, 64'(4 * i), (i % 2 == 1) ? 8'hF0 : 8'h0F, 1'b0);
         tick();
      end
      instr_addr_i = 64'h14;
      #1;
      check("full_mem_req",   64'(mem_req_o), 64'd0);
      check("full_instr_gnt", 64'(instr_gnt_o), 64'd0);
      tick();
      instr_rready_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = RD_PAT;
      #1;
      check("bp_rready",  64'(mem_rready_o), 64'd0);
      check("bp_rvalid",  64'(instr_rvalid_o), 64'd1);
      check("bp_mem_req", 64'(mem_req_o), 64'd0);
      tick();
      instr_rready_i = 1'b1;
      exp_rsp(0, d_of[0], 4'h0, 1'b0);
      #1;
      check("pop_cycle_mem_req", 64'(mem_req_o), 64'd0);
      tick();
      mem_rvalid_i = 1'b0;
      exp_gnt(0, 64'h14, 8'hF0, 1'b0);
      #1;
      check("after_pop_mem_req", 64'(mem_req_o), 64'd1);
      tick();
      instr_req_i = 1'b0; mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = RD_PAT;
      for (int i = 1; i < 4; i++) begin
         exp_rsp(0, d_of[i], 4'h0, 1'b0);
         tick();
      end
      exp_rsp(0, 64'hDEAD_BEEF, 4'h0, 1'b0);
      tick();
      idle();

      // flush discards two in-flight fetches
      tick();
      instr_req_i = 1'b1; instr_addr_i = 64'h0; mem_gnt_i = 1'b1;
      exp_gnt(0, 64'h0, 8'h0F, 1'b0);
      tick();
      instr_addr_i = 64'h4;
      exp_gnt(0, 64'h4, 8'hF0, 1'b0);
      tick();
      flush = 1'b1;
      #1;
      check("flush_mem_req",   64'(mem_req_o), 64'd0);
      check("flush_instr_gnt", 64'(instr_gnt_o), 64'd0);
      tick();
      flush = 1'b0; instr_req_i = 1'b0; mem_gnt_i = 1'b0;
      instr_rready_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = RD_PAT;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("flushed_rvalid", 64'(instr_rvalid_o), 64'd0);
         check("flushed_rready", 64'(mem_rready_o), 64'd1);
         tick();
      end
      mem_rvalid_i = 1'b0; instr_rready_i = 1'b1;
      instr_req_i = 1'b1; instr_addr_i = 64'h4; mem_gnt_i = 1'b1;
      exp_gnt(0, 64'h4, 8'hF0, 1'b0);
      tick();
      instr_req_i = 1'b0; mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = RD_PAT;
      exp_rsp(0, 64'hDEAD_BEEF, 4'h0, 1'b0);
      tick();
      idle();

      // reset with three loads outstanding
      tick();
      load_req_i = 1'b1; load_be_i = 8'hFF; mem_gnt_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         load_addr_i = 64'h500 + 64'(8 * i); load_tag_i = 4'(7 + i);
         exp_gnt(1, 64'h500 + 64'(8 * i), 8'hFF, 1'b0);
         tick();
      end
      rst_n = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = RD_PAT;
      #1;
      check("rst2_mem_req",  64'(mem_req_o), 64'd0);
      check("rst2_load_gnt", 64'(load_gnt_o), 64'd0);
      check("rst2_rvalid",   64'(load_rvalid_o), 64'd0);
      check("rst2_rready",   64'(mem_rready_o), 64'd1);
      tick();
      load_req_i = 1'b0; mem_gnt_i = 1'b0;
      rst_n = 1'b1;
      #1;
      check("spur_rvalid", 64'({instr_rvalid_o, load_rvalid_o, store_rvalid_o}), 64'd0);
      check("spur_rready", 64'(mem_rready_o), 64'd1);
      tick();
      mem_rvalid_i = 1'b0;
      load_req_i = 1'b1; load_addr_i = 64'h600; load_tag_i = 4'hA; mem_gnt_i = 1'b1;
      exp_gnt(1, 64'h600, 8'hFF, 1'b0);
      tick();
      load_req_i = 1'b0; mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0102_0304_0506_0708; mem_tag_i = 4'hA;
      exp_rsp(1, 64'h0102_0304_0506_0708, 4'hA, 1'b0);
      tick();
      idle();
      tick(); tick();

      check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
      check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/len5_mem_arbiter.md
LEN5_MEM_ARBITER -- requirements
Module: len5_mem_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data/address width.
REQ-002 Parameter TAG_W, default 4, load/store tag width.
REQ-003 Parameter MAX_OUTST, default 4, maximum outstanding granted requests (power of 2, >=2).
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 flush_i  in  1  fetch flush; in-flight instruction responses are discarded.
REQ-007 instr_req_i / instr_gnt_o / instr_rvalid_o / instr_rready_i  1 each  fetch handshake; instr_addr_i XLEN in; instr_rdata_o 32 out; instr_except_raised_o 1 out; instr_except_code_o except_code_t out.
REQ-008 load_req_i / load_gnt_o / load_rvalid_o / load_rready_i  1 each; load_addr_i XLEN, load_be_i 8, load_tag_i TAG_W in; load_rdata_o XLEN, load_tag_o TAG_W, load_except_raised_o 1, load_except_code_o except_code_t out.
REQ-009 store_req_i / store_gnt_o / store_rvalid_o / store_rready_i  1 each; store_addr_i XLEN, store_be_i 8, store_wdata_i XLEN, store_tag_i TAG_W in; store_tag_o TAG_W, store_except_raised_o 1, store_except_code_o except_code_t out.
REQ-010 mem_req_o / mem_gnt_i / mem_rvalid_i / mem_rready_o  1 each; mem_we_o 1, mem_addr_o XLEN, mem_be_o 8, mem_wdata_o XLEN, mem_tag_o TAG_W out; mem_rdata_i XLEN, mem_tag_i TAG_W, mem_except_raised_i 1, mem_except_code_i except_code_t in. Memory responds in request order.

Function
REQ-011 Requester IDs: INSTR=0, LOAD=1, STORE=2.
REQ-012 Request path combinational: mem_* request fields driven from selected requester in same cycle; mem_req_o = selected req AND outstanding FIFO not full.
REQ-013 Instruction request: mem_we_o=0, mem_wdata_o=0, mem_tag_o=0, mem_be_o=8'h0F if instr_addr_i[2]=0 else 8'hF0. Load: we=0. Store: we=1.
REQ-014 gnt routed only to selected requester: <src>_gnt_o = mem_gnt_i AND mem_req_o AND selected==src; others 0.
REQ-015 Lock: if mem_req_o=1 and mem_gnt_i=0, selection registered and held next cycle regardless of other requests; lock released on grant.
REQ-016 FIFO full (MAX_OUTST entries): mem_req_o=0, all gnt=0, no selection change.
REQ-017 On each grant push entry {src, addr[2], drop=0} into outstanding FIFO.
REQ-018 Response routed combinationally to FIFO head src: <src>_rvalid_o = mem_rvalid_i AND NOT drop; mem_rready_o = head src rready, or 1 if drop; pop on mem_rvalid_i AND mem_rready_o.
REQ-019 instr_rdata_o = mem_rdata_i[31:0] if head addr[2]=0 else [63:32]; load/store tag, rdata, except fields pass through.
REQ-020 flush_i=1: set drop on every INSTR entry in FIFO (including entry pushed same cycle); instr_req_i ignored that cycle; held instr lock released.
REQ-021 mem_rvalid_i with empty FIFO: ignored, mem_rready_o=1, no rvalid out, no state change.
REQ-022 Simultaneous push and pop on full FIFO permitted only as pop-then-push next cycle; grant blocked while full (REQ-016).

Reset
REQ-023 rst_ni=0 asynchronously: FIFO empty, pointers 0, lock cleared, round-robin pointer = INSTR.
REQ-024 During reset all gnt/rvalid outputs and mem_req_o are 0; mem_rready_o=1.

Configuration
REQ-025 Macro LEN5_ARB_RR_EN defined: round-robin among pending requesters, search starting at ID after last granted, pointer updated on grant only.
REQ-026 LEN5_ARB_RR_EN undefined: fixed priority STORE > LOAD > INSTR, no pointer register.

Verification
REQ-027 All three req=1 same cycle, gnt always 1, fixed priority: grants STORE, LOAD, INSTR in consecutive cycles only as each req drops; RR build: INSTR, LOAD, STORE order.
REQ-028 load_req=1 addr 0x100, mem_gnt=0 for 3 cycles, store_req asserted cycle 2 -> mem_addr_o stays 0x100 until gnt; store granted after.
REQ-029 MAX_OUTST=4, 5 instr grants with no rvalid -> 5th request: mem_req_o=0 until first response popped.
REQ-030 2 instr grants outstanding, flush_i pulse, 2 responses -> instr_rvalid_o stays 0, mem_rready_o=1, FIFO empty after.
REQ-031 Instr addr 0x1004, mem_rdata 0xAAAA_BBBB_CCCC_DDDD -> mem_be_o=8'hF0, instr_rdata_o=0xAAAABBBB.
REQ-032 rst_ni low with 3 entries outstanding -> FIFO empty, spurious mem_rvalid_i ignored after reset.
